pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use and other Tuse/Tnew data hazards by comparing the decode stage against the EX and MEM stages.
- Owns the multiply/divide busy counter and stalls decode for any HI/LO-class instruction while the unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- D_rs  input  5  rs field of the instruction in ID.
- D_rt  input  5  rt field of the instruction in ID.
- D_Tuse_rs  input  2  cycles until ID needs rs; 3 means rs is unused.
- D_Tuse_rt  input  2  cycles until ID needs rt; 3 means rt is unused.
- D_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_RegAddr  input  5  destination register of the EX instruction; 0 means none.
- E_Tnew  input  2  cycles until the EX result is available.
- M_RegAddr  input  5  destination register of the MEM instruction.
- M_Tnew  input  2  cycles until the MEM result is available.
- E_start  input  1  mult/div issues in EX this cycle.
- E_is_div  input  1  qualifies E_start: 1 = div/divu, 0 = mult/multu.
- PC_en  output  1  PC register enable.
- IF_ID_en  output  1  IF/ID register enable.
- ID_EX_flush  output  1  ID/EX register reset (inserts a bubble).
- EX_MEM_en  output  1  EX/MEM register enable; constant 1.
- MEM_WB_en  output  1  MEM/WB register enable; constant 1.
- md_busy  output  1  multiply/divide unit busy.
- stall_count  output  32  registered count of stall cycles, saturating.

Behaviour:
- Hazard terms:
  - hz_E_rs = (D_rs != 0) && (D_rs == E_RegAddr) && (D_Tuse_rs < E_Tnew).
  - hz_E_rt, hz_M_rs and hz_M_rt are formed the same way, substituting rt and/or M_RegAddr/M_Tnew.
  - A Tuse of 3 can never be less than a 2-bit Tnew, so it never stalls.
- md_stall = D_md && (md_busy || E_start).
- stall = OR of the four hazard terms and md_stall. stall is combinational, with zero-cycle latency from the inputs and from busy_cnt.
- Output equations:
  - PC_en = !stall.
  - IF_ID_en = !stall.
  - ID_EX_flush = stall.
  - EX_MEM_en = 1 and MEM_WB_en = 1 at all times, so later stages always drain.
- Busy counter busy_cnt[CNT_W-1:0]:
  - On E_start, load DIV_CYCLES if E_is_div, else MULT_CYCLES.
  - Else if busy_cnt != 0, decrement by 1.
  - Else hold at 0.
  - md_busy = (busy_cnt != 0).
- E_start while busy: reload the counter (the later start wins). In correct operation this cannot occur because md_stall blocks it.
- E_start and decrement in the same cycle: the load takes priority.
- stall_count: increments by 1 on every clk edge where stall = 1, saturating at 32'hFFFF_FFFF with no wrap.
- Reset (asynchronous, any time, including mid-countdown):
  - busy_cnt = 0, so md_busy = 0.
  - stall_count = 0.
  - With all inputs at 0 after reset: PC_en = 1, IF_ID_en = 1, ID_EX_flush = 0, EX_MEM_en = 1, MEM_WB_en = 1.
  - Clearing takes effect immediately on reset assertion, not at the next edge.
- No other state. All combinational outputs depend only on the current inputs and busy_cnt.

Test Plan:
- Load-use: E_RegAddr=8, E_Tnew=2, D_rs=8, D_Tuse_rs=1 -> PC_en=0, IF_ID_en=0, ID_EX_flush=1. Changing D_Tuse_rs to 2 -> stall=0.
- $0 and MEM path:
  - D_rt=0, E_RegAddr=0, E_Tnew=2, D_Tuse_rt=0 -> no stall.
  - M_RegAddr=9, M_Tnew=1, D_rt=9, D_Tuse_rt=0 -> stall=1.
- Mult countdown: E_start=1, E_is_div=0 for one cycle -> md_busy=1 for exactly 5 cycles, then 0. With D_md=1 held throughout -> stall is high in the start cycle plus 5 busy cycles, and stall_count=6.
- Div with reset mid-operation: E_start=1, E_is_div=1, then assert reset after 4 busy cycles -> md_busy=0 and stall_count=0 immediately, before the next edge. Non-md hazards are unaffected.
- Simultaneous events: E_start (div) asserted in the cycle busy_cnt=1 from a prior mult -> busy_cnt=10 next cycle, with no decrement applied.
- Saturation: force stall_count to 32'hFFFF_FFFE, hold stall=1 for 3 cycles -> stall_count=32'hFFFF_FFFF and it stays there.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller for the 5-stage MIPS pipeline.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   D_rs/D_rt           - source register fields of the decode instruction
//   D_Tuse_rs/D_Tuse_rt - cycles until decode needs each source (3 = unused)
//   D_md                - decode instruction touches the mult/div unit or HI/LO
//   E_RegAddr/E_Tnew    - EX destination and cycles until its result is ready
//   M_RegAddr/M_Tnew    - MEM destination and cycles until its result is ready
//   E_start/E_is_div    - mult/div issuing in EX, and whether it is a divide
//   PC_en/IF_ID_en      - front-end register enables, low while stalling
//   ID_EX_flush         - bubble insertion into ID/EX while stalling
//   EX_MEM_en/MEM_WB_en - back-end enables, always 1 so later stages drain
//   md_busy             - mult/div unit still counting down
//   stall_count         - saturating count of stalled cycles
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_md,
    input  logic [4:0]  E_RegAddr,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_RegAddr,
    input  logic [1:0]  M_Tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        PC_en,
    output logic        IF_ID_en,
    output logic        ID_EX_flush,
    output logic        EX_MEM_en,
    output logic        MEM_WB_en,
    output logic        md_busy,
    output logic [31:0] stall_count
);
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [31:0]      stall_count_q, stall_count_d;
    logic             hz_e_rs, hz_e_rt, hz_m_rs, hz_m_rt, md_stall, stall;
    always_comb begin
        // $0 never carries a real dependency; Tuse=3 can never be below a 2-bit Tnew
        hz_e_rs = (D_rs != 5'd0) && (D_rs == E_RegAddr) && (D_Tuse_rs < E_Tnew);
        hz_e_rt = (D_rt != 5'd0) && (D_rt == E_RegAddr) && (D_Tuse_rt < E_Tnew);
        hz_m_rs = (D_rs != 5'd0) && (D_rs == M_RegAddr) && (D_Tuse_rs < M_Tnew);
        hz_m_rt = (D_rt != 5'd0) && (D_rt == M_RegAddr) && (D_Tuse_rt < M_Tnew);
        // a start in EX this cycle blocks decode just like an already-busy unit
        md_stall = D_md && ((busy_cnt_q != '0) || E_start);
        stall = hz_e_rs || hz_e_rt || hz_m_rs || hz_m_rt || md_stall;
        // a new start overrides any countdown in progress
        busy_cnt_d = E_start ? (E_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES))
                   : (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
        stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF)) ? stall_count_q + 32'd1
                      : stall_count_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_q    <= '0;
            stall_count_q <= '0;
        end else begin
            busy_cnt_q    <= busy_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end
    assign PC_en       = !stall;
    assign IF_ID_en    = !stall;
    assign ID_EX_flush = stall;
    assign EX_MEM_en   = 1'b1;
    assign MEM_WB_en   = 1'b1;
    assign md_busy     = (busy_cnt_q != '0);
    assign stall_count = stall_count_q;
endmodule
